// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg -- shared definitions for the sequence controller.
//   state_t      : controller state encoding (IDLE=0, RUN=1, PAUSE=2)
//   ADDR_W       : width of the table address
//   COUNT_W      : width of the in-step tick counter
//   STEP_LEN_DEF : default number of ticks per address step
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int ADDR_W       = 4;
    localparam int COUNT_W      = 8;
    localparam int STEP_LEN_DEF = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage : seq_pkg

// File: rtl/seq_ctrl_tick_div.sv
// -----------------------------------------------------------------------------
// tick_div -- clock prescaler producing a one-clock tick every DIV enabled clocks.
//   clk   in  : system clock, rising edge
//   rst_n in  : asynchronous active-low reset
//   clr   in  : synchronous clear of the prescaler count (wins over en)
//   en    in  : count enable; the prescaler holds its value while low
//   tick  out : high in the cycle whose closing edge completes DIV enabled clocks
// The first tick after a clear arrives DIV enabled clocks later.
// -----------------------------------------------------------------------------
module tick_div #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule : tick_div

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl -- address sequencer: walks addr from 0 to a latched last_addr,
// spending STEP_LEN prescaled ticks on each address, then pulses done.
//   Parameters : DIV      clocks per tick (1..65535)
//                STEP_LEN ticks per address step (2..255)
//   clk        in  : system clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   start      in  : start request (honoured only in IDLE, and not with stop)
//   stop       in  : abort; beats tick, pause and start
//   pause      in  : level; freezes addr, count and prescaler while high
//   last_addr  in  : final address, latched when a run starts
//   loop       in  : (SEQ_CTRL_LOOP_EN only) restart from 0 instead of finishing
//   addr       out : current table address, registered
//   count      out : tick count within the current step, registered
//   busy       out : high in RUN or PAUSE
//   done       out : one-cycle pulse on normal completion
// Optional feature macro: SEQ_CTRL_LOOP_EN adds the loop input.
// -----------------------------------------------------------------------------
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned DIV      = 1,
    parameter int unsigned STEP_LEN = STEP_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [ADDR_W-1:0]  last_addr,
    output logic [ADDR_W-1:0]  addr,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done
`ifdef SEQ_CTRL_LOOP_EN
    ,
    input  logic               loop
`endif
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(STEP_LEN - 1);

    state_t             state, state_next;
    logic [ADDR_W-1:0]  last_q, last_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [COUNT_W-1:0] count_next;
    logic               done_next;
    logic               loop_en;
    logic               tick_en;
    logic               tick;
    logic               clr;

`ifdef SEQ_CTRL_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    // Progress is gated by the pause level rather than by the state alone: the
    // edge that leaves PAUSE already advances, so a pause of N cycles delays
    // completion by exactly N cycles.
    assign tick_en = (state != IDLE) && !pause && !stop;

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_q <= '0;
            addr   <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            last_q <= last_next;
            addr   <= addr_next;
            count  <= count_next;
            done   <= done_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        last_next  = last_q;
        addr_next  = addr;
        count_next = count;
        done_next  = 1'b0;
        clr        = 1'b0;

        case (state)
            IDLE: begin
                // Keep the prescaler at zero so the first tick lands DIV
                // clocks after the start edge.
                clr = 1'b1;
                if (start && !stop) begin
                    state_next = RUN;
                    last_next  = last_addr;
                    addr_next  = '0;
                    count_next = '0;
                end
            end

            RUN, PAUSE: begin
                if (stop) begin
                    state_next = IDLE;
                    addr_next  = '0;
                    count_next = '0;
                    clr        = 1'b1;
                end else if (pause) begin
                    state_next = PAUSE;
                end else begin
                    state_next = RUN;
                    if (tick) begin
                        if (count != LAST_COUNT) begin
                            count_next = count + COUNT_W'(1);
                        end else if (addr != last_q) begin
                            count_next = '0;
                            addr_next  = addr + ADDR_W'(1);
                        end else if (loop_en) begin
                            count_next = '0;
                            addr_next  = '0;
                        end else begin
                            state_next = IDLE;
                            addr_next  = '0;
                            count_next = '0;
                            done_next  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
                addr_next  = '0;
                count_next = '0;
            end
        endcase
    end

    // Decoded from the registered state, so busy has already dropped in the
    // cycle that done is high.
    assign busy = (state != IDLE);

endmodule : seq_ctrl

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning clocks per tick (1..65535).
REQ-002 SHALL have parameter STEP_LEN, default 13, meaning ticks per address step (2..255).
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  sequence start request, sampled each clk.
REQ-006 SHALL have port stop  input  1  abort request.
REQ-007 SHALL have port pause  input  1  level; freezes progress while high.
REQ-008 SHALL have port last_addr  input  4  final address of sequence.
REQ-009 SHALL have port addr  output  4  current table address, registered.
REQ-010 SHALL have port count  output  8  tick count within step, registered.
REQ-011 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at normal completion.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE.
REQ-014 In IDLE, start=1 and stop=0 SHALL enter RUN at that edge, latch last_addr, clear addr, count and prescaler.
REQ-015 start while busy SHALL be ignored; last_addr changes mid-run SHALL be ignored.
REQ-016 In RUN the prescaler SHALL assert an internal tick every DIV clocks, first tick DIV clocks after entering RUN.
REQ-017 On tick with count<STEP_LEN-1, count SHALL increment by 1.
REQ-018 On tick with count=STEP_LEN-1 and addr!=latched last_addr, count SHALL wrap to 0 and addr SHALL increment by 1.
REQ-019 On tick with count=STEP_LEN-1 and addr=latched last_addr, block SHALL go to IDLE, clear addr and count, and assert done for exactly one cycle.
REQ-020 pause=1 in RUN SHALL enter PAUSE at that edge with no tick processed; PAUSE SHALL hold addr, count and prescaler; pause=0 SHALL return to RUN.
REQ-021 stop=1 in RUN or PAUSE SHALL go to IDLE, clear addr and count, with done=0; stop SHALL take priority over tick, pause and start.
REQ-022 start and stop both high in IDLE SHALL leave block in IDLE.
REQ-023 last_addr=0 SHALL give a single step of STEP_LEN ticks.
REQ-024 busy SHALL be decoded from registered state, low in same cycle done is high.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, addr=0, count=0, busy=0, done=0, prescaler=0, latched last_addr=0.
REQ-026 Reset deassertion mid-sequence SHALL NOT resume; block SHALL wait for a new start.

Configuration
REQ-027 With SEQ_CTRL_LOOP_EN defined, SHALL add input loop (1 bit); completion per REQ-019 with loop=1 SHALL wrap addr and count to 0, stay in RUN, no done pulse.
REQ-028 Without SEQ_CTRL_LOOP_EN, port loop SHALL NOT exist and behaviour SHALL be REQ-019 only.

Structure
REQ-029 Shared package seq_pkg SHALL hold state encoding (IDLE=0, RUN=1, PAUSE=2), ADDR_W=4, COUNT_W=8, default STEP_LEN=13.
REQ-030 Prescaler SHALL be sub-module tick_div (inputs clk, rst_n, clr, en; output tick).

Verification
REQ-031 DIV=1, STEP_LEN=13, last_addr=2, start pulse at edge E0 -> addr=1 after E13, addr=2 after E26, done=1 and addr=0 after E39 only, busy low after E39.
REQ-032 DIV=4, STEP_LEN=13, last_addr=0 -> count increments every 4 clocks; done after 52 clocks from start edge.
REQ-033 pause high 10 cycles at addr=1, count=5 -> addr/count frozen 10 cycles, completion delayed exactly 10 cycles.
REQ-034 stop at addr=1, count=7 -> IDLE next edge, addr=0, count=0, done never asserted; start+stop together in IDLE -> busy stays 0.
REQ-035 rst_n low mid-run at addr=3 -> all outputs 0 immediately, no activity after release until start.
REQ-036 SEQ_CTRL_LOOP_EN, loop=1, last_addr=1, STEP_LEN=13 -> addr sequence 0,1,0,1 every 13 ticks, busy stays 1, done stays 0.
